// File: rtl/hazard_freeze_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard/freeze controller:
// SRAM-wait FSM state encoding, forwarding-select codes and small
// comparator helpers used by the top level.
package hazard_freeze_ctrl_pkg;

    // Wait counter is wide enough for the largest legal MEM_WAIT_CYCLES (15).
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RELEASE  = 2'd2
    } fsm_state_t;

    // EXE operand source selects.
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // True when a read source collides with a writing destination.
    function automatic logic src_hits(input logic       use_src,
                                      input logic [3:0] src,
                                      input logic       dest_wb_en,
                                      input logic [3:0] dest);
        return use_src & dest_wb_en & (src == dest);
    endfunction

    // Operand bypass select; the younger MEM result wins over WB.
    function automatic logic [1:0] fwd_select(input logic [3:0] src,
                                              input logic       mem_wb_en,
                                              input logic [3:0] mem_dest,
                                              input logic       wb_wb_en,
                                              input logic [3:0] wb_dest);
        logic [1:0] sel;
        sel = FWD_REG;
        if (mem_wb_en && (src == mem_dest)) begin
            sel = FWD_MEM;
        end else if (wb_wb_en && (src == wb_dest)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Fixed-latency SRAM wait sequencer. Holds the whole pipeline for exactly
// MEM_WAIT_CYCLES cycles per access, then pulses o_mem_ready for one cycle
// while the MEM instruction advances. A request seen during that release
// cycle is only accepted from the following idle cycle.
module mem_wait_fsm
    import hazard_freeze_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_mem_req,
    output logic o_freeze_all,
    output logic o_mem_ready
);

    // The cycle the request is first seen in IDLE is already frozen, so the
    // counter only has to cover the remaining MEM_WAIT_CYCLES-1 cycles.
    localparam logic [WAIT_CNT_W-1:0] LOAD_VAL =
        (MEM_WAIT_CYCLES >= 2) ? WAIT_CNT_W'(MEM_WAIT_CYCLES - 2) : '0;

    fsm_state_t            r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_mem_ready;

    // State, wait counter and the registered ready pulse.
    // NOTE: every register here is written with <= so all of them update
    // together from the same pre-edge values; = would create order races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_mem_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mem_ready <= 1'b0;
                    if (i_mem_req) begin
                        if (MEM_WAIT_CYCLES == 1) begin
                            r_state     <= ST_RELEASE;
                            r_mem_ready <= 1'b1;
                        end else begin
                            r_state    <= ST_MEM_WAIT;
                            r_wait_cnt <= LOAD_VAL;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state     <= ST_RELEASE;
                        r_mem_ready <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    r_state     <= ST_IDLE;
                    r_mem_ready <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_wait_cnt  <= '0;
                    r_mem_ready <= 1'b0;
                end
            endcase
        end
    end

    // Freeze starts in the same cycle the request appears in IDLE.
    assign o_freeze_all = ~rst & (((r_state == ST_IDLE) & i_mem_req) |
                                  (r_state == ST_MEM_WAIT));
    assign o_mem_ready  = ~rst & r_mem_ready;

endmodule

// File: rtl/hazard_freeze_ctrl.sv
// ID-stage hazard and freeze controller. Detects RAW hazards between the
// decoding instruction and the EXE/MEM destinations, combines them with the
// SRAM wait freeze, and counts stalled cycles (saturating).
// Optional build macro FORWARDING_EN: hazards shrink to load-use only and
// EXE operand bypass selects are generated; otherwise fwd_sel1/2 are 0.
module hazard_freeze_ctrl
    import hazard_freeze_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 5,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic [3:0]       exe_src1,
    input  logic [3:0]       exe_src2,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    output logic             freeze_front,
    output logic             bubble,
    output logic             freeze_all,
    output logic             mem_ready,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             w_freeze_all;
    logic             w_mem_ready;
    logic             w_h1;
    logic             w_h2;
    logic             w_stall_front;
    logic [1:0]       w_fwd_sel1;
    logic [1:0]       w_fwd_sel2;
    logic [CNT_W-1:0] r_stall_cnt;

    mem_wait_fsm #(
        .MEM_WAIT_CYCLES (MEM_WAIT_CYCLES)
    ) u_mem_wait_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_mem_req    (mem_req),
        .o_freeze_all (w_freeze_all),
        .o_mem_ready  (w_mem_ready)
    );

    // RAW hazard terms for both ID sources, purely from current inputs.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_h1 = 1'b0;
        w_h2 = 1'b0;
`ifdef FORWARDING_EN
        // With bypassing only a load in EXE cannot supply its result in time.
        w_h1 = exe_mem_r_en & src_hits(id_use_src1, id_src1, exe_wb_en, exe_dest);
        w_h2 = exe_mem_r_en & src_hits(id_two_src,  id_src2, exe_wb_en, exe_dest);
`else
        w_h1 = src_hits(id_use_src1, id_src1, exe_wb_en, exe_dest) |
               src_hits(id_use_src1, id_src1, mem_wb_en, mem_dest);
        w_h2 = src_hits(id_two_src,  id_src2, exe_wb_en, exe_dest) |
               src_hits(id_two_src,  id_src2, mem_wb_en, mem_dest);
`endif
    end

    // EXE operand bypass selects.
    always_comb begin
        w_fwd_sel1 = FWD_REG;
        w_fwd_sel2 = FWD_REG;
`ifdef FORWARDING_EN
        w_fwd_sel1 = fwd_select(exe_src1, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
        w_fwd_sel2 = fwd_select(exe_src2, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
`endif
    end

`ifndef FORWARDING_EN
    // Bypass-only inputs are not consumed in the full-stall build.
    logic w_unused_fwd_inputs;
    assign w_unused_fwd_inputs = ^{exe_src1, exe_src2, wb_dest, wb_wb_en, exe_mem_r_en};
`endif

    // A full-pipe freeze already holds ID, so no bubble is inserted under it.
    assign w_stall_front = ~rst & (w_h1 | w_h2) & ~w_freeze_all;

    // Saturating count of cycles in which any freeze is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((w_stall_front | w_freeze_all) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign freeze_front = w_stall_front;
    assign bubble       = w_stall_front;
    assign freeze_all   = w_freeze_all;
    assign mem_ready    = w_mem_ready;
    assign fwd_sel1     = rst ? FWD_REG : w_fwd_sel1;
    assign fwd_sel2     = rst ? FWD_REG : w_fwd_sel2;
    assign stall_cnt    = rst ? '0 : r_stall_cnt;

endmodule
